// File: rtl/tail_light_monitor.sv
// rtl/tail_light_monitor.sv - Receive-side checker for turn-signal tail-light lamp sequences
module tail_light_monitor #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               la,
  input  logic               lb,
  input  logic               lc,
  input  logic               ra,
  input  logic               rb,
  input  logic               rc,
  input  logic               clear_fault,
  output logic               left_active,
  output logic               right_active,
  output logic               seq_done,
  output logic               seq_dir,
  output logic [COUNT_W-1:0] left_count,
  output logic [COUNT_W-1:0] right_count,
  output logic               fault,
  output logic [1:0]         fault_code
);

  // Monitor states
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_L1    = 4'd1;
  localparam logic [3:0] S_L2    = 4'd2;
  localparam logic [3:0] S_L3    = 4'd3;
  localparam logic [3:0] S_R1    = 4'd4;
  localparam logic [3:0] S_R2    = 4'd5;
  localparam logic [3:0] S_R3    = 4'd6;
  localparam logic [3:0] S_FAULT = 4'd7;
  localparam logic [3:0] S_SYNC  = 4'd8;

  // Decoded lamp pattern classes
  localparam logic [2:0] P_OFF = 3'd0;
  localparam logic [2:0] P_L1  = 3'd1;
  localparam logic [2:0] P_L2  = 3'd2;
  localparam logic [2:0] P_L3  = 3'd3;
  localparam logic [2:0] P_R1  = 3'd4;
  localparam logic [2:0] P_R2  = 3'd5;
  localparam logic [2:0] P_R3  = 3'd6;
  localparam logic [2:0] P_ILL = 3'd7;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_PATTERN = 2'b01;
  localparam logic [1:0] FC_TRANS   = 2'b10;

  logic [3:0]         state_q, state_d;
  logic [2:0]         pat;
  logic               seq_done_q, seq_done_d;
  logic               seq_dir_q, seq_dir_d;
  logic [COUNT_W-1:0] left_count_q, left_count_d;
  logic [COUNT_W-1:0] right_count_q, right_count_d;
  logic [1:0]         fault_code_q, fault_code_d;
  logic               left_active_q, right_active_q, fault_q;
  logic               in_seq_state;
  logic               legal_step;
  logic [3:0]         step_target;

  // Classify the six lamp lines into one of the seven legal patterns or illegal
  always_comb begin
    case ({la, lb, lc, ra, rb, rc})
      6'b000000: pat = P_OFF;
      6'b100000: pat = P_L1;
      6'b110000: pat = P_L2;
      6'b111000: pat = P_L3;
      6'b000100: pat = P_R1;
      6'b000110: pat = P_R2;
      6'b000111: pat = P_R3;
      default:   pat = P_ILL;
    endcase
  end

  // Per-state legal step table: which pattern advances and where it leads
  always_comb begin
    legal_step  = 1'b0;
    step_target = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (pat == P_OFF) begin
          legal_step  = 1'b1;
          step_target = S_IDLE;
        end else if (pat == P_L1) begin
          legal_step  = 1'b1;
          step_target = S_L1;
        end else if (pat == P_R1) begin
          legal_step  = 1'b1;
          step_target = S_R1;
        end
      end
      S_L1: begin
        legal_step  = (pat == P_L2);
        step_target = S_L2;
      end
      S_L2: begin
        legal_step  = (pat == P_L3);
        step_target = S_L3;
      end
      S_L3: begin
        legal_step  = (pat == P_OFF);
        step_target = S_IDLE;
      end
      S_R1: begin
        legal_step  = (pat == P_R2);
        step_target = S_R2;
      end
      S_R2: begin
        legal_step  = (pat == P_R3);
        step_target = S_R3;
      end
      S_R3: begin
        legal_step  = (pat == P_OFF);
        step_target = S_IDLE;
      end
      default: begin
        legal_step  = 1'b0;
        step_target = S_IDLE;
      end
    endcase
  end

  assign in_seq_state = (state_q <= S_R3);

  // Next-state, completion bookkeeping and fault cause capture
  always_comb begin
    state_d       = state_q;
    seq_done_d    = 1'b0;
    seq_dir_d     = seq_dir_q;
    left_count_d  = left_count_q;
    right_count_d = right_count_q;
    fault_code_d  = fault_code_q;

    if (in_seq_state) begin
      if (pat == P_ILL) begin
        state_d      = S_FAULT;
        fault_code_d = FC_PATTERN;
      end else if (!legal_step) begin
        state_d      = S_FAULT;
        fault_code_d = FC_TRANS;
      end else begin
        state_d = step_target;
        // Only L3/R3 + OFF complete a sequence
        if (state_q == S_L3) begin
          seq_done_d   = 1'b1;
          seq_dir_d    = 1'b0;
          left_count_d = left_count_q + COUNT_W'(1);
        end else if (state_q == S_R3) begin
          seq_done_d    = 1'b1;
          seq_dir_d     = 1'b1;
          right_count_d = right_count_q + COUNT_W'(1);
        end
      end
    end else if (state_q == S_FAULT) begin
      // Lamps are ignored here; only an operator clear leaves the fault
      if (clear_fault) begin
        state_d      = S_SYNC;
        fault_code_d = FC_NONE;
      end
    end else if (state_q == S_SYNC) begin
      // Wait for the sequencer to come back to OFF before checking again
      if (pat == P_OFF) begin
        state_d = S_IDLE;
      end
    end else begin
      state_d      = S_IDLE;
      fault_code_d = FC_NONE;
    end
  end

  // State and registered outputs, all derived from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      seq_done_q     <= 1'b0;
      seq_dir_q      <= 1'b0;
      left_count_q   <= '0;
      right_count_q  <= '0;
      fault_code_q   <= FC_NONE;
      left_active_q  <= 1'b0;
      right_active_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      seq_done_q     <= seq_done_d;
      seq_dir_q      <= seq_dir_d;
      left_count_q   <= left_count_d;
      right_count_q  <= right_count_d;
      fault_code_q   <= fault_code_d;
      left_active_q  <= (state_d == S_L1) || (state_d == S_L2) || (state_d == S_L3);
      right_active_q <= (state_d == S_R1) || (state_d == S_R2) || (state_d == S_R3);
      fault_q        <= (state_d == S_FAULT);
    end
  end

  assign left_active  = left_active_q;
  assign right_active = right_active_q;
  assign seq_done     = seq_done_q;
  assign seq_dir      = seq_dir_q;
  assign left_count   = left_count_q;
  assign right_count  = right_count_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;

endmodule

// File: tb/tb_tail_light_monitor.sv
// tb/tb_tail_light_monitor.sv - Scoreboard bench for tail_light_monitor (8-bit and 2-bit counters)
module tb_tail_light_monitor;

  localparam logic [5:0] OFF = 6'b000000;
  localparam logic [5:0] L1  = 6'b100000;
  localparam logic [5:0] L2  = 6'b110000;
  localparam logic [5:0] L3  = 6'b111000;
  localparam logic [5:0] R1  = 6'b000100;
  localparam logic [5:0] R2  = 6'b000110;
  localparam logic [5:0] R3  = 6'b000111;
  localparam logic [5:0] BAD = 6'b100100;

  typedef struct packed {
    logic       la;
    logic       ra;
    logic       sd;
    logic       dir;
    logic [7:0] lc;
    logic [7:0] rc;
    logic       f;
    logic [1:0] code;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] lamps;
  logic       clr;

  logic       a_la, a_ra, a_sd, a_dir, a_f;
  logic [7:0] a_lc, a_rc;
  logic [1:0] a_code;
  logic       b_la, b_ra, b_sd, b_dir, b_f;
  logic [1:0] b_lc, b_rc;
  logic [1:0] b_code;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  tail_light_monitor #(.COUNT_W(8)) dut (
    .clk(clk), .reset(rst_n),
    .la(lamps[5]), .lb(lamps[4]), .lc(lamps[3]),
    .ra(lamps[2]), .rb(lamps[1]), .rc(lamps[0]),
    .clear_fault(clr),
    .left_active(a_la), .right_active(a_ra), .seq_done(a_sd), .seq_dir(a_dir),
    .left_count(a_lc), .right_count(a_rc), .fault(a_f), .fault_code(a_code)
  );

  tail_light_monitor #(.COUNT_W(2)) dut_w2 (
    .clk(clk), .reset(rst_n),
    .la(lamps[5]), .lb(lamps[4]), .lc(lamps[3]),
    .ra(lamps[2]), .rb(lamps[1]), .rc(lamps[0]),
    .clear_fault(clr),
    .left_active(b_la), .right_active(b_ra), .seq_done(b_sd), .seq_dir(b_dir),
    .left_count(b_lc), .right_count(b_rc), .fault(b_f), .fault_code(b_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    chk("left_active",      {7'd0, a_la},   {7'd0, e.la});
    chk("right_active",     {7'd0, a_ra},   {7'd0, e.ra});
    chk("seq_done",         {7'd0, a_sd},   {7'd0, e.sd});
    chk("seq_dir",          {7'd0, a_dir},  {7'd0, e.dir});
    chk("left_count",       a_lc,           e.lc);
    chk("right_count",      a_rc,           e.rc);
    chk("fault",            {7'd0, a_f},    {7'd0, e.f});
    chk("fault_code",       {6'd0, a_code}, {6'd0, e.code});
    chk("w2_left_active",   {7'd0, b_la},   {7'd0, e.la});
    chk("w2_right_active",  {7'd0, b_ra},   {7'd0, e.ra});
    chk("w2_seq_done",      {7'd0, b_sd},   {7'd0, e.sd});
    chk("w2_seq_dir",       {7'd0, b_dir},  {7'd0, e.dir});
    chk("w2_left_count",    {6'd0, b_lc},   {6'd0, e.lc[1:0]});
    chk("w2_right_count",   {6'd0, b_rc},   {6'd0, e.rc[1:0]});
    chk("w2_fault",         {7'd0, b_f},    {7'd0, e.f});
    chk("w2_fault_code",    {6'd0, b_code}, {6'd0, e.code});
  endtask

  // Monitor: every clock after reset the DUT presents a fresh registered result
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp_all(e);
      end
    end
  end

  // Drive one sample and queue the hand-computed result expected after the next edge
  task automatic step(input logic [5:0] p, input logic c,
                      input logic la, input logic ra, input logic sd, input logic dir,
                      input int lc, input int rc, input logic f, input logic [1:0] code);
    exp_t e;
    @(negedge clk);
    lamps = p;
    clr   = c;
    e.la = la; e.ra = ra; e.sd = sd; e.dir = dir;
    e.lc = 8'(lc); e.rc = 8'(rc); e.f = f; e.code = code;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t zero;
    checks   = 0;
    failures = 0;
    lamps    = OFF;
    clr      = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state and a single left sequence
    step(OFF, 0, 0,0,0,0, 0,0, 0,2'b00);
    step(L1,  0, 1,0,0,0, 0,0, 0,2'b00);
    step(L2,  0, 1,0,0,0, 0,0, 0,2'b00);
    step(L3,  0, 1,0,0,0, 0,0, 0,2'b00);
    step(OFF, 0, 0,0,1,0, 1,0, 0,2'b00);

    // two back-to-back right sequences
    step(R1,  0, 0,1,0,0, 1,0, 0,2'b00);
    step(R2,  0, 0,1,0,0, 1,0, 0,2'b00);
    step(R3,  0, 0,1,0,0, 1,0, 0,2'b00);
    step(OFF, 0, 0,0,1,1, 1,1, 0,2'b00);
    step(R1,  0, 0,1,0,1, 1,1, 0,2'b00);
    step(R2,  0, 0,1,0,1, 1,1, 0,2'b00);
    step(R3,  0, 0,1,0,1, 1,1, 0,2'b00);
    step(OFF, 0, 0,0,1,1, 1,2, 0,2'b00);

    // illegal pattern, lamps ignored while faulted, clear from OFF
    step(OFF, 0, 0,0,0,1, 1,2, 0,2'b00);
    step(BAD, 0, 0,0,0,1, 1,2, 1,2'b01);
    step(L1,  0, 0,0,0,1, 1,2, 1,2'b01);
    step(R2,  0, 0,0,0,1, 1,2, 1,2'b01);
    step(OFF, 1, 0,0,0,1, 1,2, 0,2'b00);
    step(OFF, 0, 0,0,0,1, 1,2, 0,2'b00);

    // skipped step, clear mid-sequence, SYNC ignores everything until OFF
    step(L1,  0, 1,0,0,1, 1,2, 0,2'b00);
    step(L3,  0, 0,0,0,1, 1,2, 1,2'b10);
    step(L3,  0, 0,0,0,1, 1,2, 1,2'b10);
    step(L2,  1, 0,0,0,1, 1,2, 0,2'b00);
    step(L3,  0, 0,0,0,1, 1,2, 0,2'b00);
    step(BAD, 0, 0,0,0,1, 1,2, 0,2'b00);
    step(OFF, 0, 0,0,0,1, 1,2, 0,2'b00);
    step(L1,  0, 1,0,0,1, 1,2, 0,2'b00);
    step(L2,  0, 1,0,0,1, 1,2, 0,2'b00);
    step(L3,  0, 1,0,0,1, 1,2, 0,2'b00);
    step(OFF, 0, 0,0,1,0, 2,2, 0,2'b00);

    // clear_fault outside FAULT has no effect; OFF->R2 from IDLE is a transition fault
    step(OFF, 1, 0,0,0,0, 2,2, 0,2'b00);
    step(L1,  1, 1,0,0,0, 2,2, 0,2'b00);
    step(L2,  1, 1,0,0,0, 2,2, 0,2'b00);
    step(L3,  1, 1,0,0,0, 2,2, 0,2'b00);
    step(OFF, 0, 0,0,1,0, 3,2, 0,2'b00);

    // further left sequences: the 2-bit instance wraps 3 -> 0 -> 1
    for (int k = 4; k <= 5; k++) begin
      step(L1,  0, 1,0,0,0, k-1,2, 0,2'b00);
      step(L2,  0, 1,0,0,0, k-1,2, 0,2'b00);
      step(L3,  0, 1,0,0,0, k-1,2, 0,2'b00);
      step(OFF, 0, 0,0,1,0, k,  2, 0,2'b00);
    end
    step(R2,  0, 0,0,0,0, 5,2, 1,2'b10);
    step(OFF, 1, 0,0,0,0, 5,2, 0,2'b00);
    step(OFF, 0, 0,0,0,0, 5,2, 0,2'b00);

    // asynchronous reset while in R2
    step(R1,  0, 0,1,0,0, 5,2, 0,2'b00);
    step(R2,  0, 0,1,0,0, 5,2, 0,2'b00);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    zero = '0;
    cmp_all(zero);
    @(negedge clk);
    lamps = R3;
    @(negedge clk);
    lamps = OFF;
    rst_n = 1'b1;
    step(OFF, 0, 0,0,0,0, 0,0, 0,2'b00);
    step(R1,  0, 0,1,0,0, 0,0, 0,2'b00);
    step(R2,  0, 0,1,0,0, 0,0, 0,2'b00);
    step(R3,  0, 0,1,0,0, 0,0, 0,2'b00);
    step(OFF, 0, 0,0,1,1, 0,1, 0,2'b00);
    step(OFF, 0, 0,0,0,1, 0,1, 0,2'b00);

    // let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
